axi4lite_wr_ctrl: RTL and testbench

AXI4LITE_WR_CTRL -- requirements
Module: axi4lite_wr_ctrl

---
 rtl/axi4lite_pkg.sv | 21 ++
 rtl/axi4lite_addr_dec.sv | 26 ++
 rtl/axi4lite_wr_ctrl.sv | 110 +++++++++++
 tb/tb_axi4lite_wr_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared state encoding and response codes for the AXI4-Lite write slave
package axi4lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HAVE_ADDR,
    HAVE_DATA,
    WRITE,
    RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Number of byte-offset bits dropped from a byte address to get a word index.
  function automatic int byte_off_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi4lite_addr_dec.sv
// rtl/axi4lite_addr_dec.sv - byte address to word index conversion and range check
module axi4lite_addr_dec import axi4lite_pkg::*; #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32
) (
  input  logic [ADDR_WIDTH-1:0]        addr,
  output logic [$clog2(MEM_DEPTH)-1:0] word_idx,
  output logic                         in_range
);

  localparam int OFF   = byte_off_bits(DATA_WIDTH);
  localparam int IDX_W = ADDR_WIDTH - OFF;
  localparam int WA    = $clog2(MEM_DEPTH);

  logic [IDX_W-1:0] full_idx;
  logic             unused_byte_off;

  assign full_idx        = addr[ADDR_WIDTH-1:OFF];
  assign unused_byte_off = ^addr[OFF-1:0];

  // The range test uses the full index so high bits beyond the memory are caught.
  assign word_idx = full_idx[WA-1:0];
  assign in_range = 32'(full_idx) < 32'(MEM_DEPTH);

endmodule

// File: rtl/axi4lite_wr_ctrl.sv
// rtl/axi4lite_wr_ctrl.sv - AXI4-Lite write slave driving a single-cycle memory write port
module axi4lite_wr_ctrl import axi4lite_pkg::*; #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [ADDR_WIDTH-1:0]        AWADDR,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [DATA_WIDTH-1:0]        WDATA,
  input  logic [DATA_WIDTH/8-1:0]      WSTRB,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic                         BVALID,
  output logic [1:0]                   BRESP,
  input  logic                         BREADY,
  output logic                         wr_en,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]        wr_data,
  output logic [DATA_WIDTH/8-1:0]      wr_strb
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int WA = $clog2(MEM_DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  wr_en_q, wr_en_d;
  logic [WA-1:0]         wr_addr_q, wr_addr_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  aw_hs, w_hs, in_range;
  logic [WA-1:0]         word_idx;

  // Readies depend on the state register alone, never on the valids.
  assign AWREADY = (state_q == IDLE) || (state_q == HAVE_DATA);
  assign WREADY  = (state_q == IDLE) || (state_q == HAVE_ADDR);
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;

  // Decode the address as it will be after this edge so wr_en can be registered.
  axi4lite_addr_dec #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_addr_dec (
    .addr    (awaddr_d),
    .word_idx(word_idx),
    .in_range(in_range)
  );

  always_comb begin
    state_d  = state_q;
    awaddr_d = aw_hs ? AWADDR : awaddr_q;
    wdata_d  = w_hs ? WDATA : wdata_q;
    wstrb_d  = w_hs ? WSTRB : wstrb_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) state_d = WRITE;
        else if (aw_hs)    state_d = HAVE_ADDR;
        else if (w_hs)     state_d = HAVE_DATA;
      end
      HAVE_ADDR: if (w_hs) state_d = WRITE;
      HAVE_DATA: if (aw_hs) state_d = WRITE;
      WRITE:     state_d = RESP;
      RESP:      if (BREADY) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    wr_en_d   = (state_d == WRITE) && (state_q != WRITE) && in_range && (wstrb_d != '0);
    wr_addr_d = word_idx;
    bvalid_d  = (state_d == RESP);
    bresp_d   = bresp_q;
    if ((state_d == WRITE) && (state_q != WRITE))
      bresp_d = in_range ? RESP_OKAY : RESP_SLVERR;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wdata_q;
  assign wr_strb = wstrb_q;

endmodule

// File: tb/tb_axi4lite_wr_ctrl.sv
// tb/tb_axi4lite_wr_ctrl.sv - directed scoreboard bench for the AXI4-Lite write slave
module tb_axi4lite_wr_ctrl;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  awaddr = '0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0, wready;
  logic        bvalid, bready = 1'b1;
  logic [1:0]  bresp;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  logic [7:0]  awaddr64 = '0;
  logic        awvalid64 = 1'b0, awready64;
  logic [63:0] wdata64 = '0;
  logic [7:0]  wstrb64 = '0;
  logic        wvalid64 = 1'b0, wready64;
  logic        bvalid64, bready64 = 1'b1;
  logic [1:0]  bresp64;
  logic        wr_en64;
  logic [4:0]  wr_addr64;
  logic [63:0] wr_data64;
  logic [7:0]  wr_strb64;

  int total = 0;
  int bad = 0;
  int pulses64 = 0;
  wr_t        exp_wr_q[$];
  logic [1:0] exp_resp_q[$];

  axi4lite_wr_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(32)) dut (
    .CLK(clk), .RST(rst),
    .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready),
    .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
    .BVALID(bvalid), .BRESP(bresp), .BREADY(bready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
  );

  axi4lite_wr_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .MEM_DEPTH(32)) dut64 (
    .CLK(clk), .RST(rst),
    .AWADDR(awaddr64), .AWVALID(awvalid64), .AWREADY(awready64),
    .WDATA(wdata64), .WSTRB(wstrb64), .WVALID(wvalid64), .WREADY(wready64),
    .BVALID(bvalid64), .BRESP(bresp64), .BREADY(bready64),
    .wr_en(wr_en64), .wr_addr(wr_addr64), .wr_data(wr_data64), .wr_strb(wr_strb64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.strb = s;
    exp_wr_q.push_back(e);
  endtask

  // Scoreboard: every memory write and every accepted response must match the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_wr_en", 64'(wr_en), 64'(0));
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check("sb_wr_addr", 64'(wr_addr), 64'(e.addr));
          check("sb_wr_data", 64'(wr_data), 64'(e.data));
          check("sb_wr_strb", 64'(wr_strb), 64'(e.strb));
        end
      end
      if (bvalid && bready) begin
        if (exp_resp_q.size() == 0) begin
          check("unexpected_bvalid", 64'(bvalid), 64'(0));
        end else begin
          check("sb_bresp", 64'(bresp), 64'(exp_resp_q.pop_front()));
        end
      end
      if (wr_en64) pulses64++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("rst_awready", 64'(awready), 64'(1));
    check("rst_wready", 64'(wready), 64'(1));
    check("rst_bvalid", 64'(bvalid), 64'(0));
    check("rst_bresp", 64'(bresp), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    check("rst_wr_strb", 64'(wr_strb), 64'(0));
    rst = 1'b0;
    tick();

    // Joint AW/W handshake
    awaddr = 8'h08; awvalid = 1'b1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    push_wr(5'd2, 32'hDEADBEEF, 4'hF);
    exp_resp_q.push_back(2'b00);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t1_wr_en", 64'(wr_en), 64'(1));
    check("t1_wr_addr", 64'(wr_addr), 64'(2));
    check("t1_bvalid_early", 64'(bvalid), 64'(0));
    tick();
    check("t1_wr_en_one_cycle", 64'(wr_en), 64'(0));
    check("t1_bvalid", 64'(bvalid), 64'(1));
    check("t1_bresp", 64'(bresp), 64'(0));
    tick();
    check("t1_bvalid_drop", 64'(bvalid), 64'(0));
    check("t1_idle_awready", 64'(awready), 64'(1));

    // Data before address
    wdata = 32'h12345678; wstrb = 4'b0101; wvalid = 1'b1;
    push_wr(5'd4, 32'h12345678, 4'b0101);
    exp_resp_q.push_back(2'b00);
    tick();
    wvalid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        awaddr = 8'h10; awvalid = 1'b1;
      end
      check("t2_awready", 64'(awready), 64'(1));
      check("t2_wready", 64'(wready), 64'(0));
      check("t2_no_wr_en", 64'(wr_en), 64'(0));
      tick();
    end
    awvalid = 1'b0;
    check("t2_wr_en", 64'(wr_en), 64'(1));
    tick();
    check("t2_bvalid", 64'(bvalid), 64'(1));
    tick();

    // Out-of-range address
    awaddr = 8'h80; awvalid = 1'b1;
    wdata = 32'hCAFE0001; wstrb = 4'hF; wvalid = 1'b1;
    exp_resp_q.push_back(2'b10);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t3_no_wr_en", 64'(wr_en), 64'(0));
    tick();
    check("t3_bvalid", 64'(bvalid), 64'(1));
    check("t3_bresp", 64'(bresp), 64'(2));
    tick();

    // Response backpressure
    bready = 1'b0;
    awaddr = 8'h0C; awvalid = 1'b1;
    wdata = 32'h0000AA55; wstrb = 4'h3; wvalid = 1'b1;
    push_wr(5'd3, 32'h0000AA55, 4'h3);
    exp_resp_q.push_back(2'b00);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("t4_bvalid_held", 64'(bvalid), 64'(1));
      check("t4_bresp_held", 64'(bresp), 64'(0));
      check("t4_awready", 64'(awready), 64'(0));
      check("t4_wready", 64'(wready), 64'(0));
      tick();
    end
    bready = 1'b1;
    tick();
    check("t4_bvalid_done", 64'(bvalid), 64'(0));
    check("t4_idle_awready", 64'(awready), 64'(1));
    check("t4_idle_wready", 64'(wready), 64'(1));

    // Reset while holding an address
    awaddr = 8'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("t5_have_addr_awready", 64'(awready), 64'(0));
    check("t5_have_addr_wready", 64'(wready), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_awready", 64'(awready), 64'(1));
    check("t5_wready", 64'(wready), 64'(1));
    check("t5_bvalid", 64'(bvalid), 64'(0));
    check("t5_wr_data_cleared", 64'(wr_data), 64'(0));
    tick();
    check("t5_no_wr_en", 64'(wr_en), 64'(0));

    // Reset while in WRITE: no response may follow
    awaddr = 8'h14; awvalid = 1'b1;
    wdata = 32'h0BADF00D; wstrb = 4'h1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t6_in_write_wr_en", 64'(wr_en), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_wr_en", 64'(wr_en), 64'(0));
    check("t6_bvalid", 64'(bvalid), 64'(0));
    check("t6_awready", 64'(awready), 64'(1));
    check("t6_wready", 64'(wready), 64'(1));
    tick();
    check("t6_no_resp", 64'(bvalid), 64'(0));
    tick();

    // 64-bit bus: 8-byte words
    awaddr64 = 8'h18; awvalid64 = 1'b1;
    wdata64 = 64'h0123456789ABCDEF; wstrb64 = 8'h0F; wvalid64 = 1'b1;
    tick();
    awvalid64 = 1'b0; wvalid64 = 1'b0;
    check("w64_wr_en", 64'(wr_en64), 64'(1));
    check("w64_wr_addr", 64'(wr_addr64), 64'(3));
    check("w64_wr_data", wr_data64, 64'h0123456789ABCDEF);
    check("w64_wr_strb", 64'(wr_strb64), 64'h0F);
    tick();
    check("w64_bvalid", 64'(bvalid64), 64'(1));
    check("w64_bresp", 64'(bresp64), 64'(0));
    tick();
    awaddr64 = 8'h18; awvalid64 = 1'b1;
    wdata64 = 64'hFFFF0000FFFF0000; wstrb64 = 8'h00; wvalid64 = 1'b1;
    tick();
    awvalid64 = 1'b0; wvalid64 = 1'b0;
    check("w64_strb0_no_wr_en", 64'(wr_en64), 64'(0));
    tick();
    check("w64_strb0_bvalid", 64'(bvalid64), 64'(1));
    check("w64_strb0_bresp", 64'(bresp64), 64'(0));
    tick();
    tick();

    check("sb_wr_queue_drained", 64'(exp_wr_q.size()), 64'(0));
    check("sb_resp_queue_drained", 64'(exp_resp_q.size()), 64'(0));
    check("w64_pulse_count", 64'(pulses64), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
